// File: rtl/dff_pipeline.sv
// dff_pipeline: WIDTH-bit delay line of STAGES registers with per-stage valid, stall, flush and occupancy
module dff_pipeline #(
  parameter int               WIDTH        = 8,
  parameter int               STAGES       = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter bit               GATE_INVALID = 1'b1,
  localparam int              OW           = $clog2(STAGES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_d_valid,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_valid,
  output logic [OW-1:0]    o_occupancy,
  output logic             o_any_valid
);
  logic [WIDTH-1:0] r_data [STAGES];
  logic [STAGES-1:0] r_v;
  logic [OW-1:0] r_occ;
  logic r_any;
  logic [STAGES-1:0] w_vin;
  logic [WIDTH-1:0] w_din [STAGES];
  logic [OW-1:0] w_occ_nxt;
  // stage k is fed by stage k-1, stage 0 by the input port; occupancy tracks entry minus exit
  always_comb begin
    w_vin = r_v << 1;
    w_vin[0] = i_d_valid;
    w_din[0] = i_d;
    for (int k = 1; k < STAGES; k++) w_din[k] = r_data[k-1];
    w_occ_nxt = r_occ + OW'(i_d_valid) - OW'(r_v[STAGES-1]);
  end
  // reset/flush empty the chain; enabled edges shift, gated data holds across bubbles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= '0;
      r_occ <= '0;
      r_any <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= RESET_VAL;
    end else if (i_clr) begin
      r_v <= '0;
      r_occ <= '0;
      r_any <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= RESET_VAL;
    end else if (i_en) begin
      r_v <= w_vin;
      r_occ <= w_occ_nxt;
      r_any <= w_occ_nxt != '0;
      for (int k = 0; k < STAGES; k++)
        if (!GATE_INVALID || w_vin[k]) r_data[k] <= w_din[k];
    end
  end
  assign o_q = r_data[STAGES-1];
  assign o_q_valid = r_v[STAGES-1];
  assign o_occupancy = r_occ;
  assign o_any_valid = r_any;
endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: directed vectors on the default pipeline plus randomized queue-model stress on 1- and 5-stage chains
module tb_dff_pipeline;
  typedef struct {
    logic en, clr, dv;
    logic [7:0] d;
    logic [7:0] q;
    logic qv;
    logic [1:0] occ;
  } vec_t;
  typedef struct {
    int tag;
    logic [15:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, dv = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic qv, anyv;
  logic [1:0] occ;
  logic s_en = 1'b0, s_clr = 1'b0, s_dv = 1'b0;
  logic [15:0] s_d = 16'h0000;
  logic [15:0] s_q1, s_q5;
  logic s_qv1, s_qv5, s_any1, s_any5;
  logic s_occ1;
  logic [2:0] s_occ5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_pipeline u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_d(d), .i_d_valid(dv),
    .o_q(q), .o_q_valid(qv), .o_occupancy(occ), .o_any_valid(anyv)
  );
  dff_pipeline #(.WIDTH(16), .STAGES(1)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(s_en), .i_clr(s_clr), .i_d(s_d), .i_d_valid(s_dv),
    .o_q(s_q1), .o_q_valid(s_qv1), .o_occupancy(s_occ1), .o_any_valid(s_any1)
  );
  dff_pipeline #(.WIDTH(16), .STAGES(5), .RESET_VAL(16'hBEEF)) u_s5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(s_en), .i_clr(s_clr), .i_d(s_d), .i_d_valid(s_dv),
    .o_q(s_q5), .o_q_valid(s_qv5), .o_occupancy(s_occ5), .o_any_valid(s_any5)
  );

  task automatic flush;
    clr = 1'b1; en = 1'b0; dv = 1'b0;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    vec_t v[4] = '{
      '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 2'd0}};
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; d = 8'hA5; dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== 8'h00 || qv !== 1'b0 || occ !== 2'd0 || anyv !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got q=%h v=%b occ=%0d any=%b want q=00 v=0 occ=0 any=0", i, q, qv, occ, anyv);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = v[i].en; clr = v[i].clr; dv = v[i].dv; d = v[i].d;
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== v[i].q || qv !== v[i].qv || occ !== v[i].occ || anyv !== (v[i].occ != 0)) begin
        errors++;
        $display("FAIL reset_release[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 i, q, qv, occ, anyv, v[i].q, v[i].qv, v[i].occ, v[i].occ != 0);
      end
    end
  endtask

  task automatic test_latency;
    vec_t v[6] = '{
      '{1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 2'd2},
      '{1'b1, 1'b0, 1'b1, 8'h33, 8'h11, 1'b1, 2'd3},
      '{1'b1, 1'b0, 1'b0, 8'hDD, 8'h22, 1'b1, 2'd2},
      '{1'b1, 1'b0, 1'b0, 8'hDD, 8'h33, 1'b1, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hDD, 8'h33, 1'b0, 2'd0}};
    flush();
    for (int i = 0; i < 6; i++) begin
      en = v[i].en; clr = v[i].clr; dv = v[i].dv; d = v[i].d;
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== v[i].q || qv !== v[i].qv || occ !== v[i].occ || anyv !== (v[i].occ != 0)) begin
        errors++;
        $display("FAIL latency[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 i, q, qv, occ, anyv, v[i].q, v[i].qv, v[i].occ, v[i].occ != 0);
      end
    end
  endtask

  task automatic test_stall;
    vec_t v[8] = '{
      '{1'b1, 1'b0, 1'b1, 8'h44, 8'h00, 1'b0, 2'd1},
      '{1'b0, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 2'd1},
      '{1'b0, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 2'd1},
      '{1'b0, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 2'd1},
      '{1'b0, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hEE, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hEE, 8'h44, 1'b1, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hEE, 8'h44, 1'b0, 2'd0}};
    flush();
    for (int i = 0; i < 8; i++) begin
      en = v[i].en; clr = v[i].clr; dv = v[i].dv; d = v[i].d;
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== v[i].q || qv !== v[i].qv || occ !== v[i].occ || anyv !== (v[i].occ != 0)) begin
        errors++;
        $display("FAIL stall[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 i, q, qv, occ, anyv, v[i].q, v[i].qv, v[i].occ, v[i].occ != 0);
      end
    end
  endtask

  task automatic test_bubble;
    vec_t v[6] = '{
      '{1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b1, 8'h66, 8'h55, 1'b1, 2'd2},
      '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h55, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h66, 1'b1, 2'd1},
      '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h66, 1'b0, 2'd0}};
    flush();
    for (int i = 0; i < 6; i++) begin
      en = v[i].en; clr = v[i].clr; dv = v[i].dv; d = v[i].d;
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== v[i].q || qv !== v[i].qv || occ !== v[i].occ || anyv !== (v[i].occ != 0)) begin
        errors++;
        $display("FAIL bubble[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 i, q, qv, occ, anyv, v[i].q, v[i].qv, v[i].occ, v[i].occ != 0);
      end
    end
  endtask

  task automatic test_flush;
    vec_t v[12] = '{
      '{1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 2'd2},
      '{1'b1, 1'b0, 1'b1, 8'h03, 8'h01, 1'b1, 2'd3},
      '{1'b1, 1'b1, 1'b1, 8'h99, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 8'hAB, 8'h00, 1'b0, 2'd1},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0}};
    flush();
    for (int i = 0; i < 12; i++) begin
      en = v[i].en; clr = v[i].clr; dv = v[i].dv; d = v[i].d;
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== v[i].q || qv !== v[i].qv || occ !== v[i].occ || anyv !== (v[i].occ != 0)) begin
        errors++;
        $display("FAIL flush[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 i, q, qv, occ, anyv, v[i].q, v[i].qv, v[i].occ, v[i].occ != 0);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_midstream;
    flush();
    en = 1'b1; dv = 1'b1; d = 8'h77;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (occ !== 2'd2 || anyv !== 1'b1) begin
      errors++;
      $display("FAIL midstream_fill got occ=%0d any=%b want occ=2 any=1", occ, anyv);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || qv !== 1'b0 || occ !== 2'd0 || anyv !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got q=%h v=%b occ=%0d any=%b want q=00 v=0 occ=0 any=0", q, qv, occ, anyv);
    end
    @(negedge clk);
    rst_n = 1'b1; dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (q !== 8'h00 || qv !== 1'b0 || occ !== 2'd0 || anyv !== 1'b0) begin
        errors++;
        $display("FAIL post_reset[%0d] got q=%h v=%b occ=%0d any=%b want q=00 v=0 occ=0 any=0", i, q, qv, occ, anyv);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_stress;
    item_t q1[$];
    item_t q5[$];
    int n = 0;
    logic [15:0] l1 = 16'h0000;
    logic [15:0] l5 = 16'hBEEF;
    logic e1, e5;
    for (int c = 0; c < 10000; c++) begin
      s_en = $urandom_range(3) != 0;
      s_clr = $urandom_range(63) == 0;
      s_dv = 1'($urandom_range(1));
      s_d = 16'($urandom);
      @(posedge clk); @(negedge clk);
      if (s_clr) begin
        q1.delete(); q5.delete();
        l1 = 16'h0000; l5 = 16'hBEEF;
      end else if (s_en) begin
        n++;
        if (s_dv) begin
          q1.push_back('{n, s_d});
          q5.push_back('{n, s_d});
        end
        while (q1.size() != 0 && n - q1[0].tag >= 1) void'(q1.pop_front());
        while (q5.size() != 0 && n - q5[0].tag >= 5) void'(q5.pop_front());
        if (q1.size() != 0 && q1[0].tag == n) l1 = q1[0].data;
        if (q5.size() != 0 && q5[0].tag == n - 4) l5 = q5[0].data;
      end
      e1 = q1.size() != 0 && q1[0].tag == n;
      e5 = q5.size() != 0 && q5[0].tag == n - 4;
      checks++;
      if (s_q1 !== l1 || s_qv1 !== e1 || s_occ1 !== 1'(q1.size()) || s_any1 !== (q1.size() != 0)) begin
        errors++;
        $display("FAIL stress_s1[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 c, s_q1, s_qv1, s_occ1, s_any1, l1, e1, q1.size(), q1.size() != 0);
      end
      checks++;
      if (s_q5 !== l5 || s_qv5 !== e5 || s_occ5 !== 3'(q5.size()) || s_any5 !== (q5.size() != 0)) begin
        errors++;
        $display("FAIL stress_s5[%0d] got q=%h v=%b occ=%0d any=%b want q=%h v=%b occ=%0d any=%b",
                 c, s_q5, s_qv5, s_occ5, s_any5, l5, e5, q5.size(), q5.size() != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
